hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Producer of the 3-bit ForwardA/ForwardB selects consumed by the EX-stage ALU operand muxes, and of the load-use stall.
//  Tracks a destination-register tag for each in-flight instruction (EX/MEM/WB) internally and compares decode-stage sources against it.
//  Forward selects are computed in ID and registered, so they are valid for the whole cycle the consumer occupies EX.
//  Sits beside the ID/EX pipeline register; drives the PC/IF-ID hold and the EX bubble.
// PARAMETERS
//  REG_AW       4   register-address width (16 GPRs)
//  CNT_W        16  width of the saturating stall counter
//  FWD_R0       0   0: register 0 is never a forwarding source or a stall cause; 1: R0 is treated like any GPR
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  id_valid     in   1      a real instruction is in ID this cycle
//  id_srcA      in   REG_AW source register feeding ALU operand A (RegData1 path)
//  id_srcA_use  in   1      instruction reads srcA; also set for LLB/LHB, which read their destination
//  id_srcB      in   REG_AW source register feeding ALU operand B (RegData2 path)
//  id_srcB_use  in   1      instruction reads srcB (arith ops, SW data)
//  id_dst       in   REG_AW destination register of the ID instruction
//  id_regwrite  in   1      ID instruction writes id_dst
//  id_memread   in   1      ID instruction is LW (result available only from WB)
//  flush        in   1      squash the ID instruction (taken branch); no tag enters EX
//  ForwardA     out  3      EX operand-A select: 3'b010 alu_out_MEM, 3'b001 WriteData, 3'b000 register file
//  ForwardB     out  3      EX operand-B select, same encoding
//  stall        out  1      hold PC and IF/ID; EX receives a bubble this edge
//  stall_count  out  CNT_W  number of stall cycles since reset, saturates at all-ones
// BEHAVIOUR
//  Tag = {valid, dst, regwrite, memread}. Tags tex, tmem, twb advance every clk: twb<=tmem; tmem<=tex.
//  tex<=bubble (valid=0) if stall|flush|~id_valid, else the ID tag.
//  Reset (async, rst_n=0): all tags invalid; ForwardA/B=3'b000; stall_count=0; stall reads 0 immediately (combinational on invalid tags).
//  A tag "hits" src s iff valid & regwrite & dst==s & (FWD_R0 | s!=0).
//  stall (combinational) = id_valid & ~flush & tex.memread & tex hits (srcA & srcA_use | srcB & srcB_use).
//  Load-use therefore costs exactly one stall cycle: next cycle the load sits in tmem, tex holds the bubble.
//  Next forward select for operand X, registered on clk:
//    000 if ~id_valid | flush | stall | ~X_use
//    010 if tex hits srcX (newest producer wins; tex never a load here, since that case stalled)
//    001 else if tmem hits srcX
//    000 otherwise. A twb hit needs no forwarding: the register file is write-through.
//  Bit 2 of ForwardA/B is reserved and always 0.
//  Latency: ID compare -> select visible 1 cycle later, aligned with the consumer's EX cycle.
//  stall_count increments on each rising clk with stall=1; it holds at 2^CNT_W-1.
//  flush and stall in the same cycle: flush wins. stall is forced 0, EX receives a bubble, and selects are 000.
//  Reset asserted mid-stall: all outputs take their reset values without waiting for clk. No partial tag survives.
// STRUCTURE
//  Shared package/include cpu_pkg holds:
//    - pipe_tag_t (valid, dst, regwrite, memread)
//    - FWD_REG=3'b000, FWD_WB=3'b001, FWD_MEM=3'b010
//  The tag pipeline and stall counter stay in this module.
//  One sub-module, fwd_select: combinational compare of one source against tex/tmem. Instantiated twice (A, B).
// TESTING
//  1. ADD r3,r1,r2 then SUB r4,r3,r5 back-to-back -> ForwardA=010 in SUB's EX cycle; ForwardB=000; stall never 1.
//  2. ADD r3 ; unrelated op ; XOR r6,r1,r3 -> ForwardB=001 in XOR's EX cycle.
//  3. LW r2 then ADD r6,r2,r2 -> stall=1 for exactly 1 cycle; stall_count=1; then ForwardA=ForwardB=001 in ADD's EX cycle.
//  4. ADD r0,r1,r2 then ADD r5,r0,r0 (FWD_R0=0) -> ForwardA=ForwardB=000; no stall, even when the producer is LW r0.
//  5. ADD r7 then ADD r7 then SUB r1,r7,r7 -> ForwardA=ForwardB=010 (newest wins, not 001).
//  6. Same stimulus as scenario 3 with flush=1 in the stall cycle, or rst_n pulsed low mid-stall.
//     -> flush: stall=0 and no count increment.
//     -> reset: stall=0, ForwardA/B=000, stall_count=0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline tag type and forward-select encodings
// for the hazard/forwarding unit.
package cpu_pkg;

  localparam int TAG_AW = 4;

  localparam logic [2:0] FWD_REG = 3'b000;
  localparam logic [2:0] FWD_WB  = 3'b001;
  localparam logic [2:0] FWD_MEM = 3'b010;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } pipe_tag_t;

  function automatic logic tag_hit(
    input pipe_tag_t         t,
    input logic [TAG_AW-1:0] s,
    input logic              r0
  );
    return t.valid & t.regwrite & (t.dst == s)
         & (r0 | (s != '0));
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-side request and EX-side forward/stall response
// of the hazard/forwarding unit.
interface hazard_fwd_unit_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [REG_AW-1:0] id_srcA;
  logic              id_srcA_use;
  logic [REG_AW-1:0] id_srcB;
  logic              id_srcB_use;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic [2:0]        ForwardA;
  logic [2:0]        ForwardB;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_srcA, id_srcA_use,
    output id_srcB, id_srcB_use, id_dst,
    output id_regwrite, id_memread, flush,
    input  ForwardA, ForwardB, stall,
    input  stall_count
  );

  modport slave (
    input  id_valid, id_srcA, id_srcA_use,
    input  id_srcB, id_srcB_use, id_dst,
    input  id_regwrite, id_memread, flush,
    output ForwardA, ForwardB, stall,
    output stall_count
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Compares one decode source against the in-flight
// tags; newest producer wins.
module fwd_select
  import cpu_pkg::*;
#(
  parameter bit FWD_R0 = 1'b0
) (
  input  logic [TAG_AW-1:0] src,
  input  logic              use_src,
  input  pipe_tag_t         tex,
  input  pipe_tag_t         tmem,
  input  pipe_tag_t         twb,
  output logic [2:0]        sel,
  output logic              load_hit
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  always_comb begin
    hit_ex  = use_src & tag_hit(tex, src, FWD_R0);
    hit_mem = use_src & tag_hit(tmem, src, FWD_R0);
    hit_wb  = use_src & tag_hit(twb, src, FWD_R0);
    load_hit = hit_ex & tex.memread;
    sel = FWD_REG;
    unique case (1'b1)
      hit_ex:
        sel = FWD_MEM;
      (~hit_ex & hit_mem):
        sel = FWD_WB;
      // write-through register file covers WB
      (~hit_ex & ~hit_mem & hit_wb):
        sel = FWD_REG;
      default:
        sel = FWD_REG;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX/MEM/WB tag pipeline, registered forward selects,
// load-use stall and saturating stall counter.
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW = TAG_AW,
  parameter int CNT_W  = 16,
  parameter bit FWD_R0 = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_unit_if.slave  bus
);

  pipe_tag_t        tex;
  pipe_tag_t        tmem;
  pipe_tag_t        twb;
  pipe_tag_t        id_tag;
  logic [2:0]       sel_a;
  logic [2:0]       sel_b;
  logic             ld_a;
  logic             ld_b;
  logic             stall;
  logic             kill;
  logic [2:0]       fwd_a;
  logic [2:0]       fwd_b;
  logic [CNT_W-1:0] cnt;

  fwd_select #(.FWD_R0(FWD_R0)) u_sel_a (
    .src      (bus.id_srcA),
    .use_src  (bus.id_srcA_use),
    .tex      (tex),
    .tmem     (tmem),
    .twb      (twb),
    .sel      (sel_a),
    .load_hit (ld_a)
  );

  fwd_select #(.FWD_R0(FWD_R0)) u_sel_b (
    .src      (bus.id_srcB),
    .use_src  (bus.id_srcB_use),
    .tex      (tex),
    .tmem     (tmem),
    .twb      (twb),
    .sel      (sel_b),
    .load_hit (ld_b)
  );

  assign stall = bus.id_valid & ~bus.flush
               & (ld_a | ld_b);
  assign kill  = ~bus.id_valid | bus.flush | stall;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = 1'b1;
    id_tag.dst      = bus.id_dst;
    id_tag.regwrite = bus.id_regwrite;
    id_tag.memread  = bus.id_memread;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tex   <= '0;
      tmem  <= '0;
      twb   <= '0;
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
      cnt   <= '0;
    end else begin
      twb   <= tmem;
      tmem  <= tex;
      tex   <= kill ? '0 : id_tag;
      fwd_a <= kill ? FWD_REG : sel_a;
      fwd_b <= kill ? FWD_REG : sel_b;
      if (stall && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.ForwardA    = fwd_a;
  assign bus.ForwardB    = fwd_b;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares.
module tb_hazard_fwd_unit;

  localparam int AW = 4;
  localparam int CW = 3;

  typedef struct {
    string      name;
    logic [2:0] fa;
    logic [2:0] fb;
    logic       st;
    int         cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   checks;
  int   passed;
  int   fails;

  hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  hazard_fwd_unit #(
    .REG_AW (AW),
    .CNT_W  (CW),
    .FWD_R0 (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, int act, int req);
    checks++;
    if (act == req) passed++;
    else begin
      fails++;
      $display("FAIL %s: got %0d, required %0d",
               n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".ForwardA"}, int'(bus.ForwardA), int'(e.fa));
      chk({e.name, ".ForwardB"}, int'(bus.ForwardB), int'(e.fb));
      chk({e.name, ".stall"}, int'(bus.stall), int'(e.st));
      chk({e.name, ".count"}, int'(bus.stall_count), e.cnt);
    end
  end

  task automatic cyc(
    input string n,
    input bit v, input int sa, input bit ua,
    input int sb, input bit ub, input int d,
    input bit rw, input bit mr, input bit fl,
    input bit rs,
    input logic [2:0] ea, input logic [2:0] eb,
    input bit es, input int ec
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rs;
    bus.id_valid    = v;
    bus.id_srcA     = AW'(sa);
    bus.id_srcA_use = ua;
    bus.id_srcB     = AW'(sb);
    bus.id_srcB_use = ub;
    bus.id_dst      = AW'(d);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.flush       = fl;
    e.name = n;
    e.fa = ea;
    e.fb = eb;
    e.st = es;
    e.cnt = ec;
    q.push_back(e);
  endtask

  task automatic bub(input string n,
                     input logic [2:0] ea,
                     input logic [2:0] eb,
                     input int ec);
    cyc(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
        ea, eb, 0, ec);
  endtask

  // ALU op: dst, srcA, srcB, both read
  task automatic alu(input string n, input int d,
                     input int sa, input int sb,
                     input logic [2:0] ea,
                     input logic [2:0] eb,
                     input bit es, input int ec);
    cyc(n, 1, sa, 1, sb, 1, d, 1, 0, 0, 1,
        ea, eb, es, ec);
  endtask

  task automatic lw(input string n, input int d,
                    input int base,
                    input logic [2:0] ea,
                    input logic [2:0] eb,
                    input int ec);
    cyc(n, 1, base, 1, 0, 0, d, 1, 1, 0, 1,
        ea, eb, 0, ec);
  endtask

  initial begin
    int e;
    int n1;
    checks = 0;
    passed = 0;
    fails  = 0;
    rst_n = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_srcA     = '0;
    bus.id_srcA_use = 1'b0;
    bus.id_srcB     = '0;
    bus.id_srcB_use = 1'b0;
    bus.id_dst      = '0;
    bus.id_regwrite = 1'b0;
    bus.id_memread  = 1'b0;
    bus.flush       = 1'b0;

    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        3'b000, 3'b000, 0, 0);
    bub("rst_rel", 3'b000, 3'b000, 0);

    alu("s1_add", 3, 1, 2, 3'b000, 3'b000, 0, 0);
    alu("s1_sub", 4, 3, 5, 3'b000, 3'b000, 0, 0);
    bub("s1_ex", 3'b010, 3'b000, 0);
    bub("s1_b", 3'b000, 3'b000, 0);

    alu("s2_add", 3, 1, 2, 3'b000, 3'b000, 0, 0);
    alu("s2_or", 8, 9, 10, 3'b000, 3'b000, 0, 0);
    alu("s2_xor", 6, 1, 3, 3'b000, 3'b000, 0, 0);
    bub("s2_ex", 3'b000, 3'b001, 0);
    bub("s2_b", 3'b000, 3'b000, 0);

    lw("s3_lw", 2, 1, 3'b000, 3'b000, 0);
    alu("s3_stall", 6, 2, 2, 3'b000, 3'b000, 1, 0);
    alu("s3_add", 6, 2, 2, 3'b000, 3'b000, 0, 1);
    bub("s3_ex", 3'b001, 3'b001, 1);
    bub("s3_b", 3'b000, 3'b000, 1);

    alu("s4_add0", 0, 1, 2, 3'b000, 3'b000, 0, 1);
    alu("s4_use0", 5, 0, 0, 3'b000, 3'b000, 0, 1);
    bub("s4_ex", 3'b000, 3'b000, 1);
    lw("s4_lw0", 0, 1, 3'b000, 3'b000, 1);
    alu("s4_use0l", 5, 0, 0, 3'b000, 3'b000, 0, 1);
    bub("s4_exl", 3'b000, 3'b000, 1);
    bub("s4_b", 3'b000, 3'b000, 1);

    alu("s5_add7a", 7, 1, 2, 3'b000, 3'b000, 0, 1);
    alu("s5_add7b", 7, 3, 4, 3'b000, 3'b000, 0, 1);
    alu("s5_sub", 1, 7, 7, 3'b000, 3'b000, 0, 1);
    bub("s5_ex", 3'b010, 3'b010, 1);
    bub("s5_b", 3'b000, 3'b000, 1);

    lw("s6f_lw", 2, 1, 3'b000, 3'b000, 1);
    cyc("s6f_flush", 1, 2, 1, 2, 1, 6, 1, 0, 1, 1,
        3'b000, 3'b000, 0, 1);
    bub("s6f_ex", 3'b000, 3'b000, 1);
    bub("s6f_b", 3'b000, 3'b000, 1);

    lw("s6r_lw", 2, 1, 3'b000, 3'b000, 1);
    alu("s6r_stall", 6, 2, 2, 3'b000, 3'b000, 1, 1);
    cyc("s6r_rst", 1, 2, 1, 2, 1, 6, 1, 0, 0, 0,
        3'b000, 3'b000, 0, 0);
    bub("s6r_rel", 3'b000, 3'b000, 0);

    // repeated load-use until the counter saturates
    for (int k = 0; k < 9; k++) begin
      e  = (k > 7) ? 7 : k;
      n1 = (e + 1 > 7) ? 7 : e + 1;
      lw("sat_lw", 2, 1, 3'b000, 3'b000, e);
      alu("sat_stall", 6, 2, 2, 3'b000, 3'b000, 1, e);
      alu("sat_add", 6, 2, 2, 3'b000, 3'b000, 0, n1);
      bub("sat_ex", 3'b001, 3'b001, n1);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d left, required 0",
               q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
